avalon_pio_in_debounced: RTL

Avalon-MM slave input PIO that samples WIDTH external pins (keys/switches) into the Qsys fabric, complementing the LED output PIO. Each pin passes through a 2-flop synchronizer and a per-bit debounce counter. Debounced edges are captured into a sticky edge-capture register. A maskable level interrupt is raised to the Nios II.

---
 rtl/avalon_pio_in_debounced.sv | 137 +++++++++++++
 1 files changed

// File: rtl/avalon_pio_in_debounced.sv
// Avalon-MM input PIO with per-pin synchronizer, debounce, sticky edge
// capture and a maskable level interrupt.

// Per-pin debounce lane: deb follows din only after din has differed from
// it for DB_CYCLES consecutive cycles.
module avalon_pio_in_db_lane #(
  parameter int DB_CYCLES = 50000,
  parameter int CW        = $clog2(DB_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic deb
);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [CW-1:0] cnt;

  // Count disagreement cycles; any return to the debounced value restarts.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
      deb <= 1'b0;
    end else if (din == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= din;
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end
endmodule

module avalon_pio_in_debounced #(
  parameter int WIDTH     = 4,
  parameter int DB_CYCLES = 50000,
  parameter int EDGE_TYPE = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             read_n,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);
  localparam int CW = $clog2(DB_CYCLES + 1);

  logic [WIDTH-1:0] sync1, sync2, deb, deb_d;
  logic [WIDTH-1:0] irq_mask, edge_capture;
  logic [WIDTH-1:0] ev, clr;
  logic             wr_en, rd_en;
  logic [31:0]      rdata;
  logic             unused_ok;

  assign wr_en = chipselect & ~write_n;
  assign rd_en = chipselect & ~read_n;

  // Only the low WIDTH bits of writedata are meaningful.
  assign unused_ok = &{1'b0, writedata};

  // Two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

  genvar i;
  generate
    for (i = 0; i < WIDTH; i++) begin : g_lane
      avalon_pio_in_db_lane #(.DB_CYCLES(DB_CYCLES), .CW(CW)) u_lane (
        .clk     (clk),
        .reset_n (reset_n),
        .din     (sync2[i]),
        .deb     (deb[i])
      );
    end
  endgenerate

  // Select which debounced transitions count as events.
  always_comb begin
    ev = '0;
    case (EDGE_TYPE)
      0:       ev = deb & ~deb_d;
      1:       ev = ~deb & deb_d;
      default: ev = deb ^ deb_d;
    endcase
  end

  // Write-1-to-clear mask for the capture register.
  always_comb begin
    clr = '0;
    if (wr_en && address == 3'd3) clr = writedata[WIDTH-1:0];
  end

  // Edge history, sticky capture (new event beats a clear), mask and irq.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      deb_d        <= '0;
      edge_capture <= '0;
      irq_mask     <= '0;
      irq          <= 1'b0;
    end else begin
      deb_d        <= deb;
      edge_capture <= (edge_capture & ~clr) | ev;
      if (wr_en && address == 3'd2) irq_mask <= writedata[WIDTH-1:0];
      irq          <= |(edge_capture & irq_mask);
    end
  end

  // Register-map read mux, zero-extended; reserved words read 0.
  always_comb begin
    rdata = '0;
    case (address)
      3'd0:    rdata[WIDTH-1:0] = deb;
      3'd1:    rdata[WIDTH-1:0] = sync2;
      3'd2:    rdata[WIDTH-1:0] = irq_mask;
      3'd3:    rdata[WIDTH-1:0] = edge_capture;
      default: rdata = '0;
    endcase
  end

  // Registered read data with latency 1; holds when not reading.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   readdata <= '0;
    else if (rd_en) readdata <= rdata;
  end
endmodule
